// File: rtl/pill_feeder_model.sv
// Plant-side stand-in for the bottling line: a pill hopper that pulses once per pill
// and a conveyor that indexes bottles on request, both clocked by the 1 kHz tick.
module pill_feeder_model #(
    parameter int PILL_PERIOD   = 250,
    parameter int PULSE_WIDTH   = 20,
    parameter int SWITCH_CYCLES = 2000,
    parameter int HOPPER_CAP    = 999,
    parameter int INIT_LEVEL    = 200,
    parameter int REFILL_AMOUNT = 100
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic       feed_en,
    input  logic       bottle_req,
    input  logic       hopper_jam,
    input  logic       conveyor_jam,
    input  logic       hopper_add,
    output logic       pill_pulse,
    output logic       bottle_ready,
    output logic [9:0] hopper_level,
    output logic       hopper_empty,
    output logic [6:0] bottle_count
);

    localparam int FW      = $clog2(PILL_PERIOD + 1);
    localparam int CW      = $clog2(SWITCH_CYCLES + 1);
    // The idle state costs one low cycle, so the gap state is one cycle shorter.
    localparam int GAP_LEN = PILL_PERIOD - PULSE_WIDTH - 1;
    localparam bit HAS_GAP = (GAP_LEN > 0);

    localparam logic [FW-1:0] PULSE_LOAD = FW'(PULSE_WIDTH - 1);
    localparam logic [FW-1:0] GAP_LOAD   = FW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
    localparam logic [CW-1:0] MOVE_LOAD  = CW'(SWITCH_CYCLES);
    localparam logic [10:0]   CAP11      = 11'(HOPPER_CAP);
    localparam logic [10:0]   REFILL11   = 11'(REFILL_AMOUNT);
    localparam logic [9:0]    INIT10     = 10'(INIT_LEVEL);

    typedef enum logic [1:0] {F_IDLE = 2'd0, F_PULSE = 2'd1, F_GAP = 2'd2} feed_state_t;
    typedef enum logic [0:0] {C_READY = 1'b0, C_MOVING = 1'b1} conv_state_t;

    feed_state_t    f_state_r, f_state_s;
    logic [FW-1:0]  f_cnt_r, f_cnt_s;
    conv_state_t    c_state_r, c_state_s;
    logic [CW-1:0]  m_cnt_r, m_cnt_s;
    logic           dispense_s, deliver_s;
    logic           add_sync_r, add_prev_r, refill_s;
    logic [10:0]    lvl_sum_s;
    logic [9:0]     lvl_next_s;

    // Feeder next-state: a started pill always runs its full pulse and gap.
    always_comb begin
        f_state_s  = f_state_r;
        f_cnt_s    = f_cnt_r;
        dispense_s = 1'b0;
        case (f_state_r)
            F_IDLE: begin
                if (feed_en && bottle_ready && !hopper_jam && (hopper_level != 10'd0)) begin
                    f_state_s  = F_PULSE;
                    f_cnt_s    = PULSE_LOAD;
                    dispense_s = 1'b1;
                end else begin
                    f_state_s = F_IDLE;
                end
            end
            F_PULSE: begin
                if (f_cnt_r != '0) begin
                    f_cnt_s = f_cnt_r - FW'(1);
                end else if (HAS_GAP) begin
                    f_state_s = F_GAP;
                    f_cnt_s   = GAP_LOAD;
                end else begin
                    f_state_s = F_IDLE;
                end
            end
            F_GAP: begin
                if (f_cnt_r != '0) begin
                    f_cnt_s = f_cnt_r - FW'(1);
                end else begin
                    f_state_s = F_IDLE;
                end
            end
            default: begin
                f_state_s = F_IDLE;
                f_cnt_s   = '0;
            end
        endcase
    end

    // Conveyor next-state: travel counter freezes while jammed; requests mid-move are dropped.
    always_comb begin
        c_state_s = c_state_r;
        m_cnt_s   = m_cnt_r;
        deliver_s = 1'b0;
        case (c_state_r)
            C_READY: begin
                if (bottle_req && bottle_ready) begin
                    c_state_s = C_MOVING;
                    m_cnt_s   = MOVE_LOAD;
                end else begin
                    c_state_s = C_READY;
                end
            end
            C_MOVING: begin
                if (conveyor_jam) begin
                    m_cnt_s = m_cnt_r;
                end else if (m_cnt_r <= CW'(1)) begin
                    c_state_s = C_READY;
                    m_cnt_s   = '0;
                    deliver_s = 1'b1;
                end else begin
                    m_cnt_s = m_cnt_r - CW'(1);
                end
            end
            default: begin
                c_state_s = C_READY;
                m_cnt_s   = '0;
            end
        endcase
    end

    // Hopper level: dispense and refill combine in 11 bits, then clamp to capacity.
    always_comb begin
        refill_s  = add_sync_r & ~add_prev_r;
        lvl_sum_s = {1'b0, hopper_level} - {10'd0, dispense_s} + (refill_s ? REFILL11 : 11'd0);
        if (lvl_sum_s > CAP11) begin
            lvl_next_s = CAP11[9:0];
        end else begin
            lvl_next_s = lvl_sum_s[9:0];
        end
    end

    // State, counter and refill-edge registers for both machines.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            f_state_r  <= F_IDLE;
            f_cnt_r    <= '0;
            c_state_r  <= C_READY;
            m_cnt_r    <= '0;
            add_sync_r <= 1'b0;
            add_prev_r <= 1'b0;
        end else begin
            f_state_r  <= f_state_s;
            f_cnt_r    <= f_cnt_s;
            c_state_r  <= c_state_s;
            m_cnt_r    <= m_cnt_s;
            add_sync_r <= hopper_add;
            add_prev_r <= add_sync_r;
        end
    end

    // Registered plant outputs.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            pill_pulse   <= 1'b0;
            bottle_ready <= 1'b1;
            hopper_level <= INIT10;
            bottle_count <= 7'd0;
        end else begin
            pill_pulse   <= (f_state_r == F_PULSE);
            bottle_ready <= (c_state_r == C_READY);
            hopper_level <= lvl_next_s;
            if (deliver_s && (bottle_count != 7'd99)) begin
                bottle_count <= bottle_count + 7'd1;
            end else begin
                bottle_count <= bottle_count;
            end
        end
    end

    assign hopper_empty = (hopper_level == 10'd0);

endmodule

// File: tb/tb_pill_feeder_model.sv
// Directed bench for pill_feeder_model using small parameters so pulse, move and
// saturation behaviour can be checked against hand-computed cycle counts.
module tb_pill_feeder_model;

    logic       clk_1khz = 1'b0;
    logic       rst;
    logic       feed_en, bottle_req, hopper_jam, conveyor_jam, hopper_add;
    logic       pill_pulse, bottle_ready, hopper_empty;
    logic [9:0] hopper_level;
    logic [6:0] bottle_count;

    int checks   = 0;
    int failures = 0;

    pill_feeder_model #(
        .PILL_PERIOD  (10),
        .PULSE_WIDTH  (3),
        .SWITCH_CYCLES(20),
        .HOPPER_CAP   (8),
        .INIT_LEVEL   (5),
        .REFILL_AMOUNT(4)
    ) dut (
        .clk_1khz    (clk_1khz),
        .rst         (rst),
        .feed_en     (feed_en),
        .bottle_req  (bottle_req),
        .hopper_jam  (hopper_jam),
        .conveyor_jam(conveyor_jam),
        .hopper_add  (hopper_add),
        .pill_pulse  (pill_pulse),
        .bottle_ready(bottle_ready),
        .hopper_level(hopper_level),
        .hopper_empty(hopper_empty),
        .bottle_count(bottle_count)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    initial begin
        int rises, high, prev, gaps_ok, low;
        int rise_t[8];

        rst = 1'b1; feed_en = 1'b0; bottle_req = 1'b0;
        hopper_jam = 1'b0; conveyor_jam = 1'b0; hopper_add = 1'b0;
        tick(3);
        check("rst_pulse", 32'(pill_pulse), 32'd0);
        check("rst_ready", 32'(bottle_ready), 32'd1);
        check("rst_level", 32'(hopper_level), 32'd5);
        check("rst_empty", 32'(hopper_empty), 32'd0);
        check("rst_count", 32'(bottle_count), 32'd0);
        rst = 1'b0;
        tick(1);

        // Continuous feed drains the hopper in exactly five pills.
        feed_en = 1'b1;
        rises = 0; high = 0; prev = 0;
        for (int c = 1; c <= 70; c++) begin
            tick(1);
            if (c == 1) check("lvl_after_first", 32'(hopper_level), 32'd4);
            if (pill_pulse === 1'b1) high++;
            if (pill_pulse === 1'b1 && prev == 0) begin
                if (rises < 8) rise_t[rises] = c;
                rises++;
            end
            prev = (pill_pulse === 1'b1) ? 1 : 0;
        end
        check("drain_rises", 32'(rises), 32'd5);
        check("drain_high", 32'(high), 32'd15);
        check("first_rise", 32'(rise_t[0]), 32'd2);
        gaps_ok = 1;
        for (int i = 0; i < 4; i++) if (rise_t[i+1] - rise_t[i] != 10) gaps_ok = 0;
        check("rise_spacing", 32'(gaps_ok), 32'd1);
        check("drain_level", 32'(hopper_level), 32'd0);
        check("drain_empty", 32'(hopper_empty), 32'd1);

        // Refill while starved restarts feeding; further refills clamp at capacity.
        hopper_add = 1'b1; tick(1);
        hopper_add = 1'b0; tick(1);
        check("refill_level", 32'(hopper_level), 32'd4);
        check("refill_empty", 32'(hopper_empty), 32'd0);
        check("refill_nopulse", 32'(pill_pulse), 32'd0);
        tick(1);
        check("refill_dispense", 32'(hopper_level), 32'd3);
        tick(1);
        check("refill_pulse", 32'(pill_pulse), 32'd1);
        feed_en = 1'b0; hopper_add = 1'b1; tick(1);
        hopper_add = 1'b0; tick(1);
        check("refill_7", 32'(hopper_level), 32'd7);
        hopper_add = 1'b1; tick(1);
        hopper_add = 1'b0; tick(1);
        check("refill_sat", 32'(hopper_level), 32'd8);
        hopper_add = 1'b1; tick(1);
        hopper_add = 1'b0; tick(1);
        check("refill_hold", 32'(hopper_level), 32'd8);
        tick(12);

        // Plain move, with a second request mid-move that must be dropped.
        bottle_req = 1'b1; tick(1);
        bottle_req = 1'b0;
        low = 0;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (bottle_ready === 1'b0) low++;
            bottle_req = (c == 5) ? 1'b1 : 1'b0;
        end
        check("move_low", 32'(low), 32'd20);
        check("move_count", 32'(bottle_count), 32'd1);

        // Jam for seven cycles stretches the move by seven.
        bottle_req = 1'b1; tick(1);
        bottle_req = 1'b0;
        low = 0;
        for (int c = 1; c <= 50; c++) begin
            tick(1);
            if (bottle_ready === 1'b0) low++;
            if (c == 5) conveyor_jam = 1'b1;
            if (c == 12) conveyor_jam = 1'b0;
        end
        check("jam_low", 32'(low), 32'd27);
        check("jam_count", 32'(bottle_count), 32'd2);

        // Hopper jam mid-pulse: pulse completes, nothing new until released.
        feed_en = 1'b1;
        rises = 0; high = 0; prev = 0;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (pill_pulse === 1'b1) high++;
            if (pill_pulse === 1'b1 && prev == 0) rises++;
            prev = (pill_pulse === 1'b1) ? 1 : 0;
            if (c == 2) hopper_jam = 1'b1;
        end
        check("hjam_rises", 32'(rises), 32'd1);
        check("hjam_high", 32'(high), 32'd3);
        hopper_jam = 1'b0;
        rises = 0; prev = 0;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (pill_pulse === 1'b1 && prev == 0) rises++;
            prev = (pill_pulse === 1'b1) ? 1 : 0;
        end
        check("hjam_release", 32'(rises), 32'd1);
        feed_en = 1'b0;
        check("hjam_level", 32'(hopper_level), 32'd6);

        // Asynchronous reset in the middle of a pulse and a move.
        hopper_add = 1'b1; tick(1);
        hopper_add = 1'b0; tick(1);
        check("pre_rst_level", 32'(hopper_level), 32'd8);
        feed_en = 1'b1; bottle_req = 1'b1; tick(1);
        bottle_req = 1'b0; tick(1);
        check("mid_pulse", 32'(pill_pulse), 32'd1);
        check("mid_move", 32'(bottle_ready), 32'd0);
        check("mid_level", 32'(hopper_level), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("arst_pulse", 32'(pill_pulse), 32'd0);
        check("arst_ready", 32'(bottle_ready), 32'd1);
        check("arst_level", 32'(hopper_level), 32'd5);
        check("arst_count", 32'(bottle_count), 32'd0);
        @(negedge clk_1khz);
        rst = 1'b0; feed_en = 1'b0;
        tick(3);
        check("post_rst_pulse", 32'(pill_pulse), 32'd0);
        check("post_rst_ready", 32'(bottle_ready), 32'd1);

        // One hundred deliveries saturate the bottle counter at 99.
        for (int n = 1; n <= 100; n++) begin
            bottle_req = 1'b1; tick(1);
            bottle_req = 1'b0; tick(22);
            if (n == 98) check("count_98", 32'(bottle_count), 32'd98);
            if (n == 99) check("count_99", 32'(bottle_count), 32'd99);
        end
        check("count_sat", 32'(bottle_count), 32'd99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
